sample_capture: RTL
===================

SAMPLE_CAPTURE -- requirements
Module: sample_capture

Interface
REQ-001 The module SHALL have parameter DEPTH, default 256, the number of samples per frame, which equals the display buffer length.
REQ-002 The module SHALL have parameter AUTO_TIMEOUT, default 4096, the number of decimated samples to wait for a trigger before auto-triggering.
REQ-003 Port clk, input, 1 bit: single clock (pixel/system clock).
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port adc_data, input, 12 bits: unsigned ADC sample, valid when adc_valid=1.
REQ-006 Port adc_valid, input, 1 bit: single-cycle sample strobe; no backpressure.
REQ-007 Port trigger_level, input, 12 bits: rising-edge trigger threshold.
REQ-008 Port trig_mode, input, 2 bits: 00 free-run, 01 normal (wait for trigger), 10 auto (trigger or timeout), 11 treated as 01.
REQ-009 Port scale_time, input, 4 bits: decimation; store one of every scale_time+1 accepted samples.
REQ-010 Port vblnk, input, 1 bit: vertical blank from the VGA timing chain, used for buffer publish.
REQ-011 Port data_display, output, unpacked array [0:DEPTH-1] of 12 bits: published frame read by the display drawer.
REQ-012 Port capturing, output, 1 bit: high while in state CAPTURE.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse when a new frame is published.

Function
REQ-014 States SHALL be ARMED, CAPTURE and HOLD, in a registered FSM.
REQ-015 The decimation counter SHALL increment on each adc_valid, and the sample is decimated-accepted when counter >= scale_time, after which the counter returns to 0; a mid-run scale_time change SHALL never stall.
REQ-016 In ARMED, the module SHALL keep prev_sample and a prev_valid flag updated on every decimated sample.
REQ-017 A trigger SHALL occur on a decimated sample when prev_valid=1, prev_sample < trigger_level and adc_data >= trigger_level.
REQ-018 In free-run mode, every decimated sample in ARMED SHALL act as a trigger.
REQ-019 In auto mode, a timeout counter SHALL count decimated samples in ARMED, and reaching AUTO_TIMEOUT-1 SHALL act as a trigger.
REQ-020 On a trigger, the triggering sample SHALL be written to shadow[0], the write index set to 1, and the FSM moved to CAPTURE.
REQ-021 In CAPTURE, each decimated sample SHALL be written to shadow[idx] and idx incremented; writing index DEPTH-1 SHALL move the FSM to HOLD.
REQ-022 In HOLD, adc_valid SHALL be ignored, with no writes and no decimation counting.
REQ-023 In HOLD, on a vblnk rising edge (vblnk=1 and registered vblnk=0) all of shadow SHALL be copied to data_display in one cycle and frame_done pulsed in the same registered cycle; the FSM then enters ARMED with prev_valid=0 and timeout=0.
REQ-024 data_display SHALL change only in the cycle after a vblnk rising edge, so the drawer never sees a torn frame.
REQ-025 A vblnk held high on entry to HOLD SHALL NOT publish; only the next rising edge publishes.
REQ-026 frame_done and the data_display update SHALL both appear 1 cycle after the vblnk edge cycle.
REQ-027 Changing trigger_level or trig_mode during CAPTURE SHALL NOT affect the frame in progress.

Reset
REQ-028 On rst=1 at a clk edge, state SHALL become ARMED and idx, the decimation counter, the timeout counter and prev_valid SHALL become 0.
REQ-029 On reset, capturing and frame_done SHALL become 0 and every data_display entry SHALL become 12'h000.
REQ-030 Shadow memory contents need not be reset.
REQ-031 A reset during CAPTURE or HOLD SHALL abort the frame without publishing.

Structure
REQ-032 DISPLAY_SAMPLES (256) and the capture state enum SHALL live in vga_pkg.
REQ-033 Edge comparison and the prev_sample register SHALL live in sub-module trigger_detect (clk, rst, sample, strobe, level, clear, trig).

Verification
REQ-034 Normal mode, level 2048, ramp 0..4095 step 16 with scale_time=0 -> capture starts at sample 2048, publish at the next vblnk rise gives data_display[0]=2048 and [255]=6128 mod 4096 = 2032.
REQ-035 Free-run, scale_time=3, 1024 strobes of a counter value -> data_display[k]=4k+3, and frame_done pulses exactly once.
REQ-036 Auto mode, constant input 100, level 2048, AUTO_TIMEOUT=16 -> capture starts on the 16th decimated sample, and all 256 entries equal 100.
REQ-037 vblnk high throughout HOLD -> no publish until vblnk falls and rises again, with data_display stable in between.
REQ-038 rst asserted at idx=100 -> data_display remains all zero, capturing=0, and the next trigger restarts at shadow[0].
REQ-039 First sample after reset is 3000 with level 2048 in normal mode -> no trigger (prev_valid=0).

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the scope capture path.
// Sample width, frame length, capture FSM states and trigger modes.
package vga_pkg;

    localparam int SAMPLE_W        = 12;
    localparam int DISPLAY_SAMPLES = 256;
    localparam int DEC_W           = 4;

    typedef enum logic [1:0] {
        CAP_ARMED   = 2'b00,
        CAP_CAPTURE = 2'b01,
        CAP_HOLD    = 2'b10
    } cap_state_t;

    typedef enum logic [1:0] {
        TRIG_FREE   = 2'b00,
        TRIG_NORMAL = 2'b01,
        TRIG_AUTO   = 2'b10,
        TRIG_RSVD   = 2'b11
    } trig_mode_t;

    // The reserved encoding behaves exactly like normal mode.
    function automatic trig_mode_t decode_mode(input logic [1:0] m);
        trig_mode_t t;
        t = trig_mode_t'(m);
        if (t == TRIG_RSVD)
            t = TRIG_NORMAL;
        return t;
    endfunction

endpackage

// File: rtl/trigger_detect.sv
// Rising-edge threshold detector on the decimated sample stream.
// Holds the previous decimated sample and whether it is meaningful.
import vga_pkg::*;

module trigger_detect (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                strobe,
    input  logic [SAMPLE_W-1:0] level,
    input  logic                clear,
    output logic                trig
);

    logic [SAMPLE_W-1:0] prev_sample;
    logic                prev_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_sample <= '0;
            prev_valid  <= 1'b0;
        end else if (clear) begin
            prev_valid  <= 1'b0;
        end else if (strobe) begin
            prev_sample <= sample;
            prev_valid  <= 1'b1;
        end
    end

    assign trig = strobe && prev_valid
               && (prev_sample < level)
               && (sample >= level);

endmodule

// File: rtl/sample_capture.sv
// Triggered, decimated frame capture into a shadow buffer that is
// published to the display array on a vblnk rising edge only.
import vga_pkg::*;

module sample_capture #(
    parameter int DEPTH        = DISPLAY_SAMPLES,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SAMPLE_W-1:0] adc_data,
    input  logic                adc_valid,
    input  logic [SAMPLE_W-1:0] trigger_level,
    input  logic [1:0]          trig_mode,
    input  logic [DEC_W-1:0]    scale_time,
    input  logic                vblnk,
    output logic [SAMPLE_W-1:0] data_display [0:DEPTH-1],
    output logic                capturing,
    output logic                frame_done
);

    localparam int IW = $clog2(DEPTH);
    localparam int TW = $clog2(AUTO_TIMEOUT) + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(AUTO_TIMEOUT - 1);

    cap_state_t          state;
    logic [IW-1:0]       idx;
    logic [DEC_W-1:0]    dec_cnt;
    logic [TW-1:0]       timeout;
    logic                vblnk_q;
    logic [SAMPLE_W-1:0] shadow [0:DEPTH-1];

    trig_mode_t          mode;
    logic                dec_hit;
    logic                armed_hit;
    logic                edge_trig;
    logic                fire;
    logic                vblnk_rise;
    logic                publish;
    logic                wr_en;
    logic [IW-1:0]       wr_addr;

    assign mode       = decode_mode(trig_mode);
    assign dec_hit    = adc_valid && (state != CAP_HOLD)
                     && (dec_cnt >= scale_time);
    assign armed_hit  = dec_hit && (state == CAP_ARMED);
    assign vblnk_rise = vblnk && !vblnk_q;
    assign publish    = (state == CAP_HOLD) && vblnk_rise;

    trigger_detect u_trig (
        .clk    (clk),
        .rst    (rst),
        .sample (adc_data),
        .strobe (armed_hit),
        .level  (trigger_level),
        .clear  (publish),
        .trig   (edge_trig)
    );

    always_comb begin
        fire = 1'b0;
        unique case (mode)
            TRIG_FREE:   fire = armed_hit;
            TRIG_NORMAL: fire = edge_trig;
            TRIG_AUTO:   fire = edge_trig
                             || (armed_hit && timeout == TO_LAST);
            default:     fire = edge_trig;
        endcase
    end

    assign wr_en   = fire
                  || ((state == CAP_CAPTURE) && dec_hit);
    assign wr_addr = fire ? '0 : idx;

    // Shadow RAM carries no reset; it is only ever read at publish.
    always_ff @(posedge clk) begin
        if (wr_en)
            shadow[wr_addr] <= adc_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CAP_ARMED;
            idx          <= '0;
            dec_cnt      <= '0;
            timeout      <= '0;
            vblnk_q      <= 1'b0;
            capturing    <= 1'b0;
            frame_done   <= 1'b0;
            data_display <= '{default: '0};
        end else begin
            vblnk_q    <= vblnk;
            frame_done <= 1'b0;

            if (adc_valid && state != CAP_HOLD)
                dec_cnt <= dec_hit ? '0 : dec_cnt + DEC_W'(1);

            unique case (state)
                CAP_ARMED: begin
                    if (fire) begin
                        idx       <= IW'(1);
                        timeout   <= '0;
                        state     <= CAP_CAPTURE;
                        capturing <= 1'b1;
                    end else if (armed_hit && mode == TRIG_AUTO) begin
                        timeout <= timeout + TW'(1);
                    end
                end
                CAP_CAPTURE: begin
                    if (dec_hit) begin
                        if (idx == LAST_IDX) begin
                            state     <= CAP_HOLD;
                            capturing <= 1'b0;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                CAP_HOLD: begin
                    if (vblnk_rise) begin
                        data_display <= shadow;
                        frame_done   <= 1'b1;
                        idx          <= '0;
                        timeout      <= '0;
                        state        <= CAP_ARMED;
                    end
                end
                default: begin
                    state     <= CAP_ARMED;
                    capturing <= 1'b0;
                end
            endcase
        end
    end

endmodule
